// File: rtl/ad7606_ctrl.sv
// AD7606 parallel-interface sequencer: ADC reset, CONVST, BUSY tracking,
// then a CS-framed RD burst that streams one sample per channel.
module ad7606_ctrl #(
  parameter int NCH     = 8,
  parameter int RST_CYC = 4,
  parameter int CONV_LO = 2,
  parameter int RD_LO   = 2,
  parameter int RD_HI   = 2,
  parameter int TIMEOUT = 512
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [2:0]  os_i,
  output logic [2:0]  os_o,
  output logic        adc_reset_o,
  output logic        convst_o,
  output logic        cs_o,
  output logic        rd_o,
  input  logic [15:0] db_i,
  input  logic        busy_i,
  input  logic        frstdata_i,
  output logic        ready_o,
  output logic [15:0] data_o,
  output logic [2:0]  chan_o,
  output logic        valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int M1 = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int M2 = (CONV_LO > RD_LO) ? CONV_LO : RD_LO;
  localparam int M3 = (M2 > RD_HI) ? M2 : RD_HI;
  localparam int CMAX = (M1 > M3) ? M1 : M3;
  localparam int CW = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_END  = cnt_t'(RST_CYC - 1);
  localparam cnt_t CONV_END = cnt_t'(CONV_LO - 1);
  localparam cnt_t RDLO_END = cnt_t'(RD_LO - 1);
  localparam cnt_t RDHI_END = cnt_t'(RD_HI - 1);
  localparam cnt_t TO_END   = cnt_t'(TIMEOUT - 1);
  localparam logic [2:0] LAST = 3'(NCH - 1);

  typedef enum logic [2:0] {
    S_ADCRST,
    S_IDLE,
    S_CONV,
    S_WRISE,
    S_WFALL,
    S_RDLO,
    S_RDHI
  } state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d, cnt_inc;
  logic [2:0]  chan_q, chan_d;
  logic [2:0]  os_d;
  logic        adcrst_d, convst_d, cs_d, rd_d;
  logic        ready_d, valid_d, done_d, err_d;
  logic [15:0] data_d;
  logic [2:0]  chano_d;
  logic [1:0]  code_d;

  // saturating so a stalled state can never wrap back into range
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + cnt_t'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc;
    chan_d   = chan_q;
    os_d     = os_o;
    adcrst_d = adc_reset_o;
    convst_d = convst_o;
    cs_d     = cs_o;
    rd_d     = rd_o;
    ready_d  = ready_o;
    data_d   = data_o;
    chano_d  = chan_o;
    code_d   = err_code_o;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_ADCRST: begin
        if (cnt_q == RST_END) begin
          adcrst_d = 1'b0;
          ready_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          os_d     = os_i;
          ready_d  = 1'b0;
          convst_d = 1'b0;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_END) begin
          convst_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_WRISE;
        end
      end
      S_WRISE: begin
        if (busy_i) begin
          cnt_d   = '0;
          state_d = S_WFALL;
        end else if (cnt_q == TO_END) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_WFALL: begin
        if (!busy_i) begin
          chan_d  = '0;
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RDLO;
        end else if (cnt_q == TO_END) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          cs_d    = 1'b1;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_RDLO: begin
        if (cnt_q == RDLO_END) begin
          data_d  = db_i;
          chano_d = chan_q;
          valid_d = 1'b1;
          // FRSTDATA must be high on channel 0 and low on channel 1
          if ((chan_q == 3'd0 && !frstdata_i) ||
              (chan_q == 3'd1 && frstdata_i)) begin
            err_d  = 1'b1;
            code_d = 2'b11;
          end
          rd_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_RDHI;
        end
      end
      S_RDHI: begin
        if (cnt_q == RDHI_END) begin
          cnt_d = '0;
          if (chan_q < LAST) begin
            chan_d  = chan_q + 3'd1;
            rd_d    = 1'b0;
            state_d = S_RDLO;
          end else begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_ADCRST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_ADCRST;
      cnt_q       <= '0;
      chan_q      <= '0;
      os_o        <= '0;
      adc_reset_o <= 1'b1;
      convst_o    <= 1'b1;
      cs_o        <= 1'b1;
      rd_o        <= 1'b1;
      ready_o     <= 1'b0;
      data_o      <= '0;
      chan_o      <= '0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      os_o        <= os_d;
      adc_reset_o <= adcrst_d;
      convst_o    <= convst_d;
      cs_o        <= cs_d;
      rd_o        <= rd_d;
      ready_o     <= ready_d;
      data_o      <= data_d;
      chan_o      <= chano_d;
      valid_o     <= valid_d;
      done_o      <= done_d;
      err_o       <= err_d;
      err_code_o  <= code_d;
    end
  end

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Bench for ad7606_ctrl: behavioural AD7606 model plus pin/stream monitor,
// directed scenarios with randomised codes, OS ratios and BUSY lengths.
module tb_ad7606_ctrl;

  localparam int NCH = 8;

  logic        clk_i;
  logic        reset_n_i;
  logic        start_i;
  logic [2:0]  os_i;
  logic [2:0]  os_o;
  logic        adc_reset_o;
  logic        convst_o;
  logic        cs_o;
  logic        rd_o;
  logic [15:0] db_i;
  logic        busy_i;
  logic        frstdata_i;
  logic        ready_o;
  logic [15:0] data_o;
  logic [2:0]  chan_o;
  logic        valid_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  ad7606_ctrl dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .os_i(os_i), .os_o(os_o), .adc_reset_o(adc_reset_o),
    .convst_o(convst_o), .cs_o(cs_o), .rd_o(rd_o), .db_i(db_i),
    .busy_i(busy_i), .frstdata_i(frstdata_i), .ready_o(ready_o),
    .data_o(data_o), .chan_o(chan_o), .valid_o(valid_o),
    .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks;
  int errors;
  int cyc;

  // ADC model controls
  int          busy_mode;   // 0 normal, 1 stuck low, 2 stuck high
  int          busy_delay;
  int          busy_len;
  bit          force0;
  logic [15:0] codes [NCH];
  int          busy_set_cyc;

  // monitor results
  logic [15:0] got_d [$];
  logic [2:0]  got_c [$];
  int          lo_q [$];
  int          hi_q [$];
  int          cl_q [$];
  int          done_cnt, err_cnt, err_cyc, rise_cyc;
  int          cs_falls, rd_bad;
  logic [1:0]  err_code_seen;
  logic        err_valid;
  logic [2:0]  err_chan;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_c.delete();
    lo_q.delete();
    hi_q.delete();
    cl_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    err_cyc  = -1;
    rise_cyc = -1;
    cs_falls = 0;
    rd_bad   = 0;
    err_code_seen = '0;
    err_valid = 1'b0;
    err_chan  = '0;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // pin/stream monitor
  initial begin
    logic pcs, prd, pcv;
    int run, cl;
    pcs = 1'b1; prd = 1'b1; pcv = 1'b1; run = 0; cl = 0;
    forever begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        got_d.push_back(data_o);
        got_c.push_back(chan_o);
      end
      if (done_o === 1'b1) done_cnt++;
      if (err_o === 1'b1) begin
        err_cnt++;
        err_cyc = cyc;
        err_code_seen = err_code_o;
        err_valid = valid_o;
        err_chan = chan_o;
      end
      if (pcv === 1'b0 && convst_o === 1'b1) rise_cyc = cyc;
      if (convst_o === 1'b0) cl++;
      else if (pcv === 1'b0) begin
        cl_q.push_back(cl);
        cl = 0;
      end
      if (cs_o === 1'b0) begin
        if (pcs === 1'b1) begin
          cs_falls++;
          run = 1;
        end else if (rd_o === prd) run++;
        else begin
          if (prd) hi_q.push_back(run);
          else lo_q.push_back(run);
          run = 1;
        end
      end else if (pcs === 1'b0) begin
        if (prd) hi_q.push_back(run);
        else lo_q.push_back(run);
      end
      if (cs_o === 1'b1 && rd_o === 1'b0) rd_bad++;
      pcs = cs_o; prd = rd_o; pcv = convst_o;
    end
  end

  // behavioural AD7606: BUSY after CONVST rise, one code per RD fall
  initial begin
    logic pcv, prd;
    int bcd, bl, rdidx;
    bit armed;
    pcv = 1'b1; prd = 1'b1; bcd = 0; bl = 0; rdidx = 0; armed = 0;
    busy_i = 1'b0; db_i = '0; frstdata_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (busy_mode == 1) begin
        busy_i = 1'b0;
        armed = 0;
      end
      if (pcv === 1'b0 && convst_o === 1'b1) begin
        rdidx = 0;
        if (busy_mode != 1) begin
          armed = 1;
          bcd = busy_delay;
        end
      end else if (armed) begin
        if (bcd <= 1) begin
          busy_i = 1'b1;
          busy_set_cyc = cyc;
          armed = 0;
          bl = busy_len;
        end else bcd--;
      end else if (busy_i && busy_mode != 2) begin
        if (bl <= 1) busy_i = 1'b0;
        else bl--;
      end
      if (prd === 1'b1 && rd_o === 1'b0) begin
        db_i = (rdidx < NCH) ? codes[rdidx] : 16'hdead;
        frstdata_i = (rdidx == 0) && !force0;
        rdidx++;
      end
      pcv = convst_o; prd = rd_o;
    end
  end

  task automatic power_up(input string tag);
    int n;
    n = 0;
    while (adc_reset_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, "_adcrst_len"}, n, 4);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_pins"}, {convst_o, cs_o, rd_o}, 3'b111);
  endtask

  logic [2:0] cur_os;

  task automatic do_conv(input string tag, input int mode, input bit f0,
                         input bit extra);
    int k;
    bit pulsed;
    cur_os = 3'($urandom);
    for (int i = 0; i < NCH; i++) codes[i] = 16'($urandom);
    busy_mode = mode;
    force0 = f0;
    clear_mon();
    os_i = cur_os;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    os_i = ~cur_os;
    k = 0;
    pulsed = 0;
    while (!(done_cnt > 0 || (mode != 0 && err_cnt > 0)) && k < 3000) begin
      if (extra && !pulsed && busy_i && cyc - busy_set_cyc > 10) begin
        start_i = 1'b1;
        pulsed = 1;
      end else start_i = 1'b0;
      @(negedge clk_i);
      k++;
    end
    start_i = 1'b0;
    chk({tag, "_finished"}, k < 3000, 1);
    repeat (3) @(negedge clk_i);
    chk({tag, "_os"}, os_o, cur_os);
    chk({tag, "_ready_back"}, ready_o, 1);
  endtask

  task automatic check_read(input string tag);
    chk({tag, "_nsamp"}, got_d.size(), NCH);
    for (int i = 0; i < NCH; i++) begin
      chk({tag, "_data"}, (i < got_d.size()) ? got_d[i] : 16'hxxxx,
          codes[i]);
      chk({tag, "_chan"}, (i < got_c.size()) ? got_c[i] : 3'bxxx, i);
      chk({tag, "_rdlo"}, (i < lo_q.size()) ? lo_q[i] : -1, 2);
      chk({tag, "_rdhi"}, (i < hi_q.size()) ? hi_q[i] : -1, 2);
    end
    chk({tag, "_nlo"}, lo_q.size(), NCH);
    chk({tag, "_cs_once"}, cs_falls, 1);
    chk({tag, "_rd_outside_cs"}, rd_bad, 0);
    chk({tag, "_convst_n"}, cl_q.size(), 1);
    chk({tag, "_convst_lo"}, (cl_q.size() > 0) ? cl_q[0] : -1, 2);
    chk({tag, "_done"}, done_cnt, 1);
  endtask

  initial begin
    int k;
    checks = 0;
    errors = 0;
    reset_n_i = 1'b0;
    start_i = 1'b0;
    os_i = '0;
    busy_mode = 0;
    busy_delay = 3;
    busy_len = 200;
    force0 = 0;
    busy_set_cyc = 0;
    for (int i = 0; i < NCH; i++) codes[i] = 16'(i + 1);
    clear_mon();

    // power-up
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_adcrst", adc_reset_o, 1);
    chk("rst_pins", {convst_o, cs_o, rd_o}, 3'b111);
    chk("rst_strobes", {ready_o, valid_o, done_o, err_o}, 4'b0000);
    chk("rst_code", err_code_o, 0);
    chk("rst_data", {data_o, chan_o, os_o}, 22'd0);
    reset_n_i = 1'b1;
    power_up("pu");

    // nominal conversions
    for (int r = 0; r < 3; r++) begin
      busy_len = (r == 0) ? 200 : $urandom_range(20, 200);
      do_conv("nom", 0, 0, 0);
      check_read("nom");
      chk("nom_err", err_cnt, 0);
    end

    // BUSY never rises
    do_conv("stlo", 1, 0, 0);
    chk("stlo_nerr", err_cnt, 1);
    chk("stlo_code", err_code_seen, 2'b01);
    chk("stlo_time", err_cyc - rise_cyc, 512);
    chk("stlo_cs", cs_falls, 0);
    chk("stlo_valid", got_d.size(), 0);
    chk("stlo_done", done_cnt, 0);

    // BUSY never falls
    do_conv("sthi", 2, 0, 0);
    chk("sthi_nerr", err_cnt, 1);
    chk("sthi_code", err_code_seen, 2'b10);
    chk("sthi_time", err_cyc - busy_set_cyc, 513);
    chk("sthi_cs", cs_falls, 0);
    chk("sthi_cs_pin", cs_o, 1);
    chk("sthi_valid", got_d.size(), 0);
    chk("sthi_code_held", err_code_o, 2'b10);
    busy_mode = 1;
    repeat (4) @(negedge clk_i);
    busy_mode = 0;

    // FRSTDATA low on channel 0
    busy_len = $urandom_range(20, 100);
    do_conv("frst", 0, 1, 0);
    check_read("frst");
    chk("frst_nerr", err_cnt, 1);
    chk("frst_code", err_code_seen, 2'b11);
    chk("frst_at_ch0", {err_valid, err_chan}, 4'b1000);
    force0 = 0;

    // start during WAIT_FALL is dropped
    busy_len = 150;
    do_conv("ign", 0, 0, 1);
    check_read("ign");
    repeat (30) @(negedge clk_i);
    chk("ign_one_conv", cl_q.size(), 1);
    chk("ign_idle", {ready_o, convst_o}, 2'b11);

    // reset during channel 3 read
    busy_len = $urandom_range(20, 80);
    for (int i = 0; i < NCH; i++) codes[i] = 16'($urandom);
    clear_mon();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    while (!(got_d.size() == 3 && rd_o === 1'b0) && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    chk("abort_reach_ch3", k < 3000, 1);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    chk("abort_pins", {cs_o, rd_o, convst_o, adc_reset_o}, 4'b1111);
    chk("abort_strobes", {valid_o, done_o, ready_o}, 3'b000);
    reset_n_i = 1'b1;
    power_up("abort");
    chk("abort_no_done", done_cnt, 0);
    chk("abort_nsamp", got_d.size(), 3);

    // recovery after abort
    busy_len = $urandom_range(20, 80);
    do_conv("rec", 0, 0, 0);
    check_read("rec");
    chk("rec_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad7606_ctrl.md
Name: ad7606_ctrl

Overview:
- Clocked sequencer for the AD7606 8-channel simultaneous-sampling ADC parallel interface.
- After power-up it pulses the ADC reset. On each start request it issues a CONVST pulse, tracks BUSY, then reads all channels through CS/RD strobes.
- Each captured sample is presented on a valid-qualified stream to the FPGA datapath.
- Sits between the acquisition scheduler (drives start_i) and the ADC pins.

Parameters:
- NCH, 8: channels read per conversion (1..8).
- RST_CYC, 4: cycles adc_reset_o is held high after controller reset.
- CONV_LO, 2: cycles convst_o is held low per conversion.
- RD_LO, 2: cycles rd_o is held low per channel; data is sampled on the last of these.
- RD_HI, 2: cycles rd_o is held high between channels.
- TIMEOUT, 512: maximum cycles spent waiting for any single BUSY edge.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  synchronous reset, active low.
- start_i  in  1  conversion request; accepted only while ready_o=1.
- os_i  in  3  oversampling ratio; latched at start and driven on os_o.
- os_o  out  3  to ADC OS[2:0] pins.
- adc_reset_o  out  1  to ADC RESET, active high.
- convst_o  out  1  to ADC CONVST A/B tied; a rising edge starts conversion.
- cs_o  out  1  ADC chip select, active low.
- rd_o  out  1  ADC read strobe, active low.
- db_i  in  16  ADC data bus.
- busy_i  in  1  ADC BUSY.
- frstdata_i  in  1  ADC FRSTDATA.
- ready_o  out  1  idle, can accept start_i.
- data_o  out  16  captured sample.
- chan_o  out  3  channel index of data_o.
- valid_o  out  1  one-cycle strobe qualifying data_o and chan_o.
- done_o  out  1  one-cycle strobe after the last channel is read.
- err_o  out  1  one-cycle strobe on a timeout or FRSTDATA error.
- err_code_o  out  2  01 = BUSY rise timeout, 10 = BUSY fall timeout, 11 = FRSTDATA mismatch; held until the next error.

Behaviour:
- Reset (reset_n_i=0 at a clk_i edge) forces the following, regardless of state:
  - state=ADCRST, adc_reset_o=1, convst_o=1, cs_o=1, rd_o=1.
  - ready_o=0, valid_o=0, done_o=0, err_o=0, err_code_o=0, data_o=0, chan_o=0, os_o=0, counters=0.
  - Reset mid-read aborts immediately; no done_o is issued.
- All outputs are registered. Inputs busy_i, frstdata_i and db_i are used directly; the board provides synchronisers.
- States and transitions:
  - ADCRST: adc_reset_o=1 for RST_CYC cycles, then adc_reset_o=0 -> IDLE.
  - IDLE: ready_o=1. If start_i=1 at an edge: latch os_i into os_o, ready_o=0, convst_o=0 -> CONV.
  - CONV: hold convst_o=0 for CONV_LO cycles, then convst_o=1 -> WAIT_RISE.
  - WAIT_RISE: on busy_i=1 -> WAIT_FALL with the counter cleared. If the counter reaches TIMEOUT first: err_o=1, err_code_o=01 -> IDLE.
  - WAIT_FALL: on busy_i=0 -> READ_LO with chan=0, cs_o=0, rd_o=0. Timeout: err_o=1, err_code_o=10, cs_o=1 -> IDLE.
  - READ_LO: hold rd_o=0 for RD_LO cycles. On the last cycle's edge:
    - data_o=db_i, chan_o=chan, valid_o=1 for exactly one cycle.
    - Check FRSTDATA: if chan==0 and frstdata_i!=1, or chan==1 and frstdata_i!=0, then err_o=1 and err_code_o=11. The read still completes.
    - Then rd_o=1 -> READ_HI.
  - READ_HI: hold rd_o=1 for RD_HI cycles.
    - If chan<NCH-1: chan+1, rd_o=0 -> READ_LO.
    - Otherwise: cs_o=1, done_o=1 for one cycle -> IDLE.
- cs_o stays low continuously from the first RD fall to after the last RD rise. It never toggles between channels.
- start_i while ready_o=0 is ignored and not queued.
- start_i in the same cycle the controller returns to IDLE is ignored; ready_o rises one cycle later.
- Counter width is sized for TIMEOUT. It saturates, never wraps.
- A busy_i that is already high in the first WAIT_RISE cycle counts as the rise.
- Minimum start-to-done latency is CONV_LO + 2 + busy time + NCH×(RD_LO+RD_HI) cycles.

Test Plan:
- Power-up: hold reset_n_i=0 for 3 cycles, then release -> adc_reset_o=1 for exactly 4 cycles, then ready_o=1; convst_o, cs_o, rd_o all 1.
- Nominal: start_i pulse; ADC model asserts BUSY 3 cycles after the convst_o rise and holds it 200 cycles, then returns codes 1..8 -> convst_o low 2 cycles; 8 valid_o strobes with chan_o 0..7 and data_o 1..8; each rd_o low 2 / high 2; cs_o low throughout; one done_o; err_o never set.
- BUSY stuck low: start_i with busy_i=0 permanently -> err_o one cycle with err_code_o=01 exactly 512 cycles after WAIT_RISE entry; cs_o never asserted; ready_o returns to 1.
- BUSY stuck high: busy_i rises and never falls -> err_code_o=10 after 512 cycles; no valid_o; cs_o=1.
- FRSTDATA error: frstdata_i forced 0 on channel 0 -> err_o with err_code_o=11 at the channel 0 capture; all 8 samples still delivered; done_o asserted.
- Abort and ignore: assert reset_n_i=0 during channel 3 READ_LO -> next edge cs_o=1, rd_o=1, valid_o=0, no done_o, ADCRST replayed. Separately, pulse start_i during WAIT_FALL -> ignored, exactly one conversion performed.
